// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : pointer type and Gray-code helpers shared by both FIFO controllers
// Revision 1.0
// ============================================================================
package fifo_pkg;

    localparam int PTR_MAX_WD = 32;

    // Widest pointer either side may use; narrower pointers are zero-extended.
    typedef logic [PTR_MAX_WD-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < PTR_MAX_WD; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff2.sv
`default_nettype none
// ============================================================================
// sync_ff2 : two-flop clock-domain-crossing synchronizer, async active-low reset
// Revision 1.0
// ============================================================================
module sync_ff2 #(
    parameter int WD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WD-1:0] i_d,
    output logic [WD-1:0] o_q
);

    logic [WD-1:0] meta_q, meta_d;
    logic [WD-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_rd_ctrl : read-side controller of a dual-clock FIFO with 2-entry output queue
// Revision 1.0
// ============================================================================
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WD = 16,
    parameter int PTR_WD  = 10
) (
    input  logic               rclk_i,
    input  logic               rrst_ni,
    input  logic [PTR_WD:0]    wptr_gray_i,
    input  logic [DATA_WD-1:0] mem_rdata_i,
    output logic               mem_ren_o,
    output logic [PTR_WD-1:0]  mem_raddr_o,
    output logic [PTR_WD:0]    rptr_gray_o,
    output logic [DATA_WD-1:0] rdata_o,
    output logic               rvalid_o,
    input  logic               rready_i,
    output logic               mem_empty_o,
    output logic [PTR_WD:0]    rcount_o
);

    localparam int DEPTH  = 2 ** PTR_WD;
    localparam int CNT_WD = $clog2(DEPTH) + 1;

    logic [CNT_WD-1:0]  w_wsync, w_wbin, w_rgray;
    logic [CNT_WD-1:0]  rbin_q, rbin_d;
    logic [CNT_WD-1:0]  rgray_q, rgray_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflt_q, inflt_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_WD-1:0] head_q, head_d;
    logic [DATA_WD-1:0] tail_q, tail_d;
    logic               w_empty, w_pop, w_ren;
    logic [2:0]         w_committed;

    sync_ff2 #(
        .WD (CNT_WD)
    ) u_wptr_sync (
        .clk   (rclk_i),
        .rst_n (rrst_ni),
        .i_d   (wptr_gray_i),
        .o_q   (w_wsync)
    );

    assign w_wbin  = CNT_WD'(gray2bin(ptr_t'(w_wsync)));
    assign w_rgray = CNT_WD'(bin2gray(ptr_t'(rbin_q)));
    assign w_empty = (w_rgray == w_wsync);

    always_comb begin
        w_pop       = rvalid_q && rready_i;
        // Words already owned by the queue or on their way into it.
        w_committed = {1'b0, occ_q} + {2'b00, inflt_q};
        w_ren       = !w_empty && (w_committed < (3'd2 + {2'b00, w_pop}));

        rbin_d   = rbin_q + CNT_WD'(w_ren);
        rgray_d  = CNT_WD'(bin2gray(ptr_t'(rbin_d)));
        inflt_d  = w_ren;

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({inflt_q, w_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = mem_rdata_i;
                end else begin
                    tail_d = mem_rdata_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while a fresh word lands: occupancy is unchanged.
                if (occ_q == 2'd1) begin
                    head_d = mem_rdata_i;
                end else begin
                    head_d = tail_q;
                    tail_d = mem_rdata_i;
                end
            end
            default: begin
            end
        endcase
        rvalid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge rclk_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            occ_q    <= 2'd0;
            inflt_q  <= 1'b0;
            rvalid_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            occ_q    <= occ_d;
            inflt_q  <= inflt_d;
            rvalid_q <= rvalid_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    assign mem_ren_o   = w_ren;
    assign mem_raddr_o = rbin_q[PTR_WD-1:0];
    assign rptr_gray_o = rgray_q;
    assign rdata_o     = head_q;
    assign rvalid_o    = rvalid_q;
    assign mem_empty_o = w_empty;
    assign rcount_o    = w_wbin - rbin_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_ctrl : self-checking bench for fifo_rd_ctrl with a write-side model
// Revision 1.0
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int DW    = 16;
    localparam int PW    = 4;
    localparam int NW    = PW + 1;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [NW-1:0] wptr_gray;
    logic [DW-1:0] mem_rdata;
    logic          mem_ren;
    logic [PW-1:0] mem_raddr;
    logic [NW-1:0] rptr_gray;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          mem_empty;
    logic [NW-1:0] rcount;

    fifo_rd_ctrl #(
        .DATA_WD (DW),
        .PTR_WD  (PW)
    ) dut (
        .rclk_i      (clk),
        .rrst_ni     (rst_n),
        .wptr_gray_i (wptr_gray),
        .mem_rdata_i (mem_rdata),
        .mem_ren_o   (mem_ren),
        .mem_raddr_o (mem_raddr),
        .rptr_gray_o (rptr_gray),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .mem_empty_o (mem_empty),
        .rcount_o    (rcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-clock memory with a registered read port.
    logic [DW-1:0] wmem [DEPTH];
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= wmem[mem_raddr];
    end

    logic [DW-1:0] exp_q [$];
    int wr_cnt, fetch_cnt, pop_cnt, last_raddr;
    int n_checks, n_pass;
    bit wrap_seen;

    typedef struct {
        logic [NW-1:0] wgray;
        logic          rready;
        logic          ren;
        logic          rvalid;
        logic [DW-1:0] rdata;
        logic          empty;
        logic [NW-1:0] rcount;
    } vec_t;
    vec_t vec [7];

    function automatic logic [NW-1:0] b2g(input int n);
        logic [NW-1:0] v;
        v = n[NW-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wmem[wr_cnt % DEPTH] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
            wr_cnt++;
        end
        wptr_gray = b2g(wr_cnt);
    endtask

    task automatic wait_valid(input int max, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!rvalid && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(rvalid), 32'd1);
    endtask

    task automatic drain(input int max, input string name);
        int k;
        k = 0;
        rready = 1'b1;
        while (pop_cnt != wr_cnt && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(pop_cnt), 32'(wr_cnt));
        tick();
        rready = 1'b0;
    endtask

    // Scoreboard: fetch addresses follow the fetch count, pops follow write order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_ren) begin
                    check("fetch_addr", 32'(mem_raddr), 32'(fetch_cnt % DEPTH));
                    if (last_raddr == DEPTH - 1 && mem_raddr == '0) wrap_seen = 1'b1;
                    last_raddr = int'(mem_raddr);
                    fetch_cnt++;
                end
                if (rvalid && rready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pop_extra: got word 0x%0h, expected no word", rdata);
                    end else begin
                        check("pop_order", 32'(rdata), 32'(exp_q.pop_front()));
                    end
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] v;
        int pend, p0, f0, n, space, k;

        n_checks = 0; n_pass = 0;
        wr_cnt = 0; fetch_cnt = 0; pop_cnt = 0; last_raddr = -1; wrap_seen = 1'b0;
        rst_n = 1'b0; wptr_gray = '0; rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) wmem[i] = '0;

        //             wgray  rrdy  ren   rvld  rdata     empty rcount
        vec[0] = '{5'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd0};
        vec[1] = '{5'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd0};
        vec[2] = '{5'd1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd1};
        vec[3] = '{5'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd0};
        vec[4] = '{5'd1, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b1, 5'd0};
        vec[5] = '{5'd1, 1'b1, 1'b0, 1'b1, 16'hA5A5, 1'b1, 5'd0};
        vec[6] = '{5'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd0};

        repeat (3) @(negedge clk);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_ren",    32'(mem_ren), 32'd0);
        check("rst_rdata",  32'(rdata), 32'd0);
        check("rst_empty",  32'(mem_empty), 32'd1);
        check("rst_rcount", 32'(rcount), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single-word latency, cycle by cycle.
        wmem[0] = 16'hA5A5;
        exp_q.push_back(16'hA5A5);
        wr_cnt = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            wptr_gray = vec[i].wgray;
            rready    = vec[i].rready;
            @(negedge clk);
            check($sformatf("lat%0d_ren", i),    32'(mem_ren),   32'(vec[i].ren));
            check($sformatf("lat%0d_rvalid", i), 32'(rvalid),    32'(vec[i].rvalid));
            check($sformatf("lat%0d_empty", i),  32'(mem_empty), 32'(vec[i].empty));
            check($sformatf("lat%0d_rcount", i), 32'(rcount),    32'(vec[i].rcount));
            if (vec[i].rvalid) check($sformatf("lat%0d_rdata", i), 32'(rdata), 32'(vec[i].rdata));
        end

        // Streaming: one word per cycle.
        tick();
        rready = 1'b1;
        write_words(8, 16'h0000);
        wait_valid(10, "stream_start");
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(rvalid), 32'd1);
            check("stream_data", 32'(rdata), 32'(i));
            @(negedge clk);
        end
        check("stream_end", 32'(rvalid), 32'd0);

        // Backpressure: queue fills to two and the head holds.
        tick();
        rready = 1'b0;
        f0 = fetch_cnt;
        write_words(8, 16'h1000);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                check("bp_valid", 32'(rvalid), 32'd1);
                check("bp_hold", 32'(rdata), 32'h1000);
            end
        end
        check("bp_fetches", 32'(fetch_cnt - f0), 32'd2);
        tick();
        rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_rel_valid", 32'(rvalid), 32'd1);
            check("bp_rel_data", 32'(rdata), 32'h1000 + 32'(i));
        end
        @(negedge clk);
        check("bp_rel_end", 32'(rvalid), 32'd0);
        tick();
        rready = 1'b0;

        // Capture and pop on the same edge with one word queued.
        write_words(1, 16'hC0DE);
        wait_valid(10, "sim_first");
        tick();
        write_words(1, 16'hBEEF);
        k = 0;
        @(negedge clk);
        while (!mem_ren && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("sim_fetch", 32'(mem_ren), 32'd1);
        tick();
        rready = 1'b1;
        @(negedge clk);
        check("sim_pop_data", 32'(rdata), 32'hC0DE);
        tick();
        rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("sim_next_valid", 32'(rvalid), 32'd1);
            check("sim_next_data", 32'(rdata), 32'hBEEF);
        end
        tick();
        rready = 1'b1;
        tick();
        rready = 1'b0;
        @(negedge clk);
        check("sim_single", 32'(rvalid), 32'd0);

        // Full memory, then drain across the pointer wrap.
        tick();
        write_words(16, 16'h2000);
        repeat (3) @(negedge clk);
        check("full_rcount", 32'(rcount), 32'd16);
        check("full_empty", 32'(mem_empty), 32'd0);
        check("full_gray_start", 32'(rptr_gray), 32'(b2g(wr_cnt - 16)));
        wrap_seen = 1'b0;
        p0 = pop_cnt;
        pend = 4;
        tick();
        rready = 1'b1;
        for (int c = 0; c < 100 && pop_cnt - p0 < 20; c++) begin
            if (pend > 0 && wr_cnt - pop_cnt < DEPTH) begin
                v = 16'h2010 + DW'(4 - pend);
                write_words(1, v);
                pend--;
            end
            tick();
        end
        rready = 1'b0;
        check("wrap_pops", 32'(pop_cnt - p0), 32'd20);
        repeat (3) @(negedge clk);
        check("wrap_gray_end", 32'(rptr_gray), 32'(b2g(wr_cnt)));
        check("wrap_addr_15_0", 32'(wrap_seen), 32'd1);

        // Randomised traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            tick();
            rready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 3);
                space = DEPTH - (wr_cnt - pop_cnt);
                if (n > space) n = space;
                if (n > 0) write_words(n, DW'($urandom));
            end
        end
        tick();
        drain(200, "rand_drain");

        // Reset asserted with words queued.
        write_words(5, 16'h4000);
        repeat (8) @(negedge clk);
        check("mid_valid", 32'(rvalid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wptr_gray = '0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_empty", 32'(mem_empty), 32'd1);
        check("mid_rst_ren", 32'(mem_ren), 32'd0);
        check("mid_rst_rcount", 32'(rcount), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        exp_q.delete();
        wr_cnt = 0; fetch_cnt = 0; pop_cnt = 0; last_raddr = -1;
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(rvalid), 32'd0);
            check("post_rst_ren", 32'(mem_ren), 32'd0);
        end
        tick();
        write_words(2, 16'h5000);
        drain(20, "post_rst_drain");

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
